// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU datapath.
// Holds datapath sizing, instruction field positions, opcode constants and
// the writeback-register payload shared by the register-file stage.
package cpu_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned NREG = 4;
    localparam int unsigned AW   = $clog2(NREG);

    // Instruction field positions
    localparam int unsigned OP_HI    = 15;
    localparam int unsigned OP_LO    = 8;
    localparam int unsigned RD_HI    = 7;
    localparam int unsigned RD_LO    = 6;
    localparam int unsigned RM_HI    = 5;
    localparam int unsigned RM_LO    = 4;
    localparam int unsigned RN_HI    = 3;
    localparam int unsigned RN_LO    = 2;
    localparam int unsigned CUSE_BIT = 1;
    localparam int unsigned CEN_BIT  = 0;

    // Opcodes
    localparam logic [7:0] OP_ADD = 8'hF8;
    localparam logic [7:0] OP_SUB = 8'hF9;
    localparam logic [7:0] OP_INC = 8'hFA;
    localparam logic [7:0] OP_DEC = 8'hFB;

    // One-entry writeback register contents
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic          carry;
        logic          wen;
        logic          cen;
    } wb_t;

endpackage

// File: rtl/regfile4.sv
// 4 x DW architectural register storage.
// Two combinational read ports, one synchronous write port, synchronous
// active-high clear. With REGFILE_DBG_EN defined a third combinational read
// port is added for the debug tap.
// Ports:
//   clk, rst             clock, synchronous active-high clear
//   raddr1/raddr2        read addresses; rdata1_c/rdata2_c read data
//   raddr3/rdata3_c      debug read port (REGFILE_DBG_EN only)
//   we/waddr/wdata       write port
module regfile4
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
`ifdef REGFILE_DBG_EN
    input  logic [AW-1:0] raddr3,
    output logic [DW-1:0] rdata3_c,
`endif
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata1_c,
    output logic [DW-1:0] rdata2_c
);

    logic [DW-1:0] mem [NREG];

    // Storage update; clear wins over a simultaneous write
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1_c = mem[raddr1];
    assign rdata2_c = mem[raddr2];
`ifdef REGFILE_DBG_EN
    assign rdata3_c = mem[raddr3];
`endif

endmodule

// File: rtl/regfile_wb.sv
// Register-file and writeback stage of the 16-bit CPU.
// Reads rm/rn for the instruction in flight (with forwarding from the
// writeback register), captures the ALU result into a one-entry writeback
// register and commits it to the register file / carry flag on the next edge.
// Optional debug tap guarded by macro REGFILE_DBG_EN.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr, valid              instruction this cycle (rd/rm/rn fields), valid
//   aluout, carryout          ALU result and carry for instr
//   carryen, wenout           instr updates the carry flag / writes rd
//   inreg1, inreg2, carryin   forwarded operands and carry to the ALU
//   retired                   committed valid instruction count (wraps)
//   dbgsel, dbgdata, dbgcflag registered rf read and raw carry flag (debug)
module regfile_wb
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] instr,
    input  logic          valid,
    input  logic [DW-1:0] aluout,
    input  logic          carryout,
    input  logic          carryen,
    input  logic          wenout,
`ifdef REGFILE_DBG_EN
    input  logic [AW-1:0] dbgsel,
    output logic [DW-1:0] dbgdata,
    output logic          dbgcflag,
`endif
    output logic [DW-1:0] inreg1,
    output logic [DW-1:0] inreg2,
    output logic          carryin,
    output logic [DW-1:0] retired
);

    logic [AW-1:0] rd;
    logic [AW-1:0] rm;
    logic [AW-1:0] rn;
    logic [DW-1:0] rf_rd1_c;
    logic [DW-1:0] rf_rd2_c;
    logic          cflag;
    wb_t           wb;
    wb_t           wb_next_c;

    assign rd = instr[RD_HI:RD_LO];
    assign rm = instr[RM_HI:RM_LO];
    assign rn = instr[RN_HI:RN_LO];

    // Opcode and carry-control bits belong to the ALU, not this stage
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[OP_HI:OP_LO], instr[CUSE_BIT], instr[CEN_BIT]};

`ifdef REGFILE_DBG_EN
    logic [DW-1:0] rf_rd3_c;
`endif

    regfile4 u_rf (
        .clk      (clk),
        .rst      (rst),
        .raddr1   (rm),
        .raddr2   (rn),
`ifdef REGFILE_DBG_EN
        .raddr3   (dbgsel),
        .rdata3_c (rf_rd3_c),
`endif
        .we       (wb.wen),
        .waddr    (wb.rd),
        .wdata    (wb.data),
        .rdata1_c (rf_rd1_c),
        .rdata2_c (rf_rd2_c)
    );

    // Bubbles still load the register, but with write/carry enables masked
    always_comb begin
        wb_next_c       = '0;
        wb_next_c.valid = valid;
        wb_next_c.rd    = rd;
        wb_next_c.data  = aluout;
        wb_next_c.carry = carryout;
        wb_next_c.wen   = valid & wenout;
        wb_next_c.cen   = valid & carryen;
    end

    // Capture new writeback entry and commit the previous one
    always_ff @(posedge clk) begin
        if (rst) begin
            wb      <= '0;
            cflag   <= 1'b0;
            retired <= '0;
        end else begin
            wb <= wb_next_c;
            if (wb.cen) begin
                cflag <= wb.carry;
            end
            if (wb.valid) begin
                retired <= retired + DW'(1);
            end
        end
    end

    // Forwarding from the writeback register; reads of rd for the current
    // instruction see the old value since aluout only enters via wb
    always_comb begin
        inreg1  = rf_rd1_c;
        inreg2  = rf_rd2_c;
        carryin = cflag;
        if (wb.wen && (wb.rd == rm)) begin
            inreg1 = wb.data;
        end
        if (wb.wen && (wb.rd == rn)) begin
            inreg2 = wb.data;
        end
        if (wb.cen) begin
            carryin = wb.carry;
        end
    end

`ifdef REGFILE_DBG_EN
    // Architectural (unforwarded) register view, one cycle late
    always_ff @(posedge clk) begin
        if (rst) begin
            dbgdata <= '0;
        end else begin
            dbgdata <= rf_rd3_c;
        end
    end

    assign dbgcflag = cflag;
`endif

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        valid = 1'b0;
    logic [15:0] aluout = '0;
    logic        carryout = 1'b0;
    logic        carryen = 1'b0;
    logic        wenout = 1'b0;
    logic [15:0] inreg1;
    logic [15:0] inreg2;
    logic        carryin;
    logic [15:0] retired;
`ifdef REGFILE_DBG_EN
    logic [1:0]  dbgsel = '0;
    logic [15:0] dbgdata;
    logic        dbgcflag;
`endif

    int errors = 0;
    int checks = 0;

    regfile_wb dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .valid    (valid),
        .aluout   (aluout),
        .carryout (carryout),
        .carryen  (carryen),
        .wenout   (wenout),
`ifdef REGFILE_DBG_EN
        .dbgsel   (dbgsel),
        .dbgdata  (dbgdata),
        .dbgcflag (dbgcflag),
`endif
        .inreg1   (inreg1),
        .inreg2   (inreg2),
        .carryin  (carryin),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // Reference model of what a reader observes: every instruction accepted
    // at an edge is immediately visible to later readers; it counts as retired
    // one edge later; reset forgets everything, including the in-flight one.
    logic [15:0] m_rf [4] = '{default: 16'h0};
    logic        m_c    = 1'b0;
    logic [15:0] m_ret  = 16'h0;
    logic        m_pend = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rf   = '{default: 16'h0};
            m_c    = 1'b0;
            m_ret  = 16'h0;
            m_pend = 1'b0;
        end else begin
            if (m_pend) m_ret = m_ret + 16'd1;
            m_pend = valid;
            if (valid && wenout)  m_rf[instr[7:6]] = aluout;
            if (valid && carryen) m_c = carryout;
        end
    end

    function automatic logic [15:0] mk(input logic [1:0] rd, input logic [1:0] rm,
                                       input logic [1:0] rn);
        mk = {8'($urandom), rd, rm, rn, 2'($urandom)};
    endfunction

    // Drive one cycle of inputs at the falling edge, then let comb logic settle
    task automatic drive(input logic r, input logic v, input logic [15:0] ins,
                         input logic [15:0] alu, input logic co, input logic ce,
                         input logic we);
        @(negedge clk);
        rst = r; valid = v; instr = ins; aluout = alu;
        carryout = co; carryen = ce; wenout = we;
        #1;
    endtask

    task automatic test_reset;
        drive(1, 0, mk(0, 0, 0), 16'hAAAA, 1, 1, 1);
        drive(1, 1, mk(1, 1, 2), 16'h5555, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, mk(2'(i), 2'(i), 2'(3 - i)), 16'($urandom), 1, 1, 1);
            checks++;
            if (inreg1 !== 16'h0 || inreg2 !== 16'h0 || carryin !== 1'b0 || retired !== 16'h0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got in1=%h in2=%h cin=%b ret=%h required 0/0/0/0",
                         i, inreg1, inreg2, carryin, retired);
            end
        end
    endtask

    task automatic test_fwd_write_read;
        logic [15:0] base;
        base = m_ret;
        drive(0, 1, mk(1, 0, 0), 16'h1234, 0, 0, 1);
        drive(0, 0, mk(0, 1, 1), 16'h0, 0, 0, 0);
        checks++;
        if (inreg1 !== 16'h1234 || inreg2 !== 16'h1234) begin
            errors++;
            $display("FAIL fwd_read: got in1=%h in2=%h required 1234", inreg1, inreg2);
        end
        drive(0, 0, mk(0, 1, 0), 16'h0, 0, 0, 0);
        checks++;
        if (inreg1 !== 16'h1234 || retired !== base + 16'd1) begin
            errors++;
            $display("FAIL rf_read: got in1=%h ret=%h required 1234 ret=%h",
                     inreg1, retired, base + 16'd1);
        end
    endtask

    task automatic test_carry;
        logic [15:0] snap1;
        snap1 = m_rf[1];
        drive(0, 1, mk(1, 0, 0), 16'hDEAD, 1, 1, 0);
        drive(0, 0, mk(0, 1, 1), 16'h0, 0, 0, 0);
        checks++;
        if (carryin !== 1'b1 || inreg1 !== snap1) begin
            errors++;
            $display("FAIL carry_set: got cin=%b in1=%h required 1 %h", carryin, inreg1, snap1);
        end
        // carryen=0 with carryout=0 must not clear the flag
        drive(0, 1, mk(0, 0, 0), 16'h7777, 0, 0, 1);
        drive(0, 0, mk(0, 0, 0), 16'h0, 0, 0, 0);
        checks++;
        if (carryin !== 1'b1 || inreg1 !== 16'h7777) begin
            errors++;
            $display("FAIL carry_hold: got cin=%b in1=%h required 1 7777", carryin, inreg1);
        end
        drive(0, 0, mk(0, 0, 0), 16'h0, 0, 0, 0);
        checks++;
        if (carryin !== 1'b1) begin
            errors++;
            $display("FAIL carry_hold_rf: got cin=%b required 1", carryin);
        end
        // A bubble carrying carryen must not touch the flag
        drive(0, 0, mk(0, 0, 0), 16'h0, 0, 1, 1);
        drive(0, 1, mk(3, 0, 0), 16'h1111, 0, 1, 0);
        drive(0, 0, mk(0, 3, 0), 16'h0, 0, 0, 0);
        checks++;
        if (carryin !== 1'b0 || inreg1 !== m_rf[3]) begin
            errors++;
            $display("FAIL carry_clear: got cin=%b in1=%h required 0 %h", carryin, inreg1, m_rf[3]);
        end
    endtask

    task automatic test_back_to_back;
        drive(0, 1, mk(2, 0, 0), 16'h0001, 0, 0, 1);
        drive(0, 1, mk(2, 2, 2), 16'h0002, 0, 0, 1);
        checks++;
        if (inreg1 !== 16'h0001 || inreg2 !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_first: got in1=%h in2=%h required 0001", inreg1, inreg2);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, mk(0, 2, 2), 16'h0, 0, 0, 0);
            checks++;
            if (inreg1 !== 16'h0002 || inreg2 !== 16'h0002) begin
                errors++;
                $display("FAIL b2b_later[%0d]: got in1=%h in2=%h required 0002", i, inreg1, inreg2);
            end
        end
    endtask

    task automatic test_reset_midflight;
        drive(0, 1, mk(3, 0, 0), 16'hBEEF, 1, 1, 1);
        drive(1, 0, mk(0, 3, 3), 16'h0, 0, 0, 0);
        checks++;
        if (inreg1 !== 16'hBEEF) begin
            errors++;
            $display("FAIL midflight_fwd: got in1=%h required beef", inreg1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, mk(0, 3, 3), 16'h0, 0, 0, 0);
            checks++;
            if (inreg1 !== 16'h0 || inreg2 !== 16'h0 || retired !== 16'h0 || carryin !== 1'b0) begin
                errors++;
                $display("FAIL midflight_kill[%0d]: got in1=%h in2=%h ret=%h cin=%b required 0",
                         i, inreg1, inreg2, retired, carryin);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] ins;
        for (int i = 0; i < 400; i++) begin
            ins = mk(2'($urandom), 2'($urandom), 2'($urandom));
            drive(($urandom_range(0, 49) == 0), 1'($urandom), ins, 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (inreg1 !== m_rf[ins[5:4]] || inreg2 !== m_rf[ins[3:2]] ||
                carryin !== m_c || retired !== m_ret) begin
                errors++;
                $display("FAIL random[%0d]: got in1=%h in2=%h cin=%b ret=%h required %h %h %b %h",
                         i, inreg1, inreg2, carryin, retired,
                         m_rf[ins[5:4]], m_rf[ins[3:2]], m_c, m_ret);
            end
        end
    endtask

    task automatic test_counter_wrap;
        logic saw_ffff;
        logic saw_wrap;
        logic [15:0] prev;
        saw_ffff = 1'b0;
        saw_wrap = 1'b0;
        drive(1, 0, mk(0, 0, 0), 16'h0, 0, 0, 0);
        drive(0, 0, mk(0, 0, 0), 16'h0, 0, 0, 0);
        prev = retired;
        for (int i = 0; i < 80000 && !saw_wrap; i++) begin
            drive(0, (i % 8 != 7), mk(2'($urandom), 0, 1), 16'($urandom), 0, 0, 1'($urandom));
            if (retired !== m_ret) begin
                checks++;
                errors++;
                $display("FAIL wrap_count[%0d]: got ret=%h required %h", i, retired, m_ret);
            end
            if (retired === 16'hFFFF) saw_ffff = 1'b1;
            if (saw_ffff && prev === 16'hFFFF && retired === 16'h0000) saw_wrap = 1'b1;
            prev = retired;
        end
        checks++;
        if (!saw_ffff || !saw_wrap) begin
            errors++;
            $display("FAIL wrap: got saw_ffff=%b saw_wrap=%b required 1 1", saw_ffff, saw_wrap);
        end
        // Bubbles after the wrap must not advance the counter
        drive(0, 0, mk(0, 0, 0), 16'h0, 0, 0, 0);
        drive(0, 0, mk(0, 0, 0), 16'h0, 0, 0, 0);
        prev = retired;
        drive(0, 0, mk(0, 0, 0), 16'h0, 0, 0, 0);
        checks++;
        if (retired !== prev || retired !== m_ret) begin
            errors++;
            $display("FAIL wrap_bubble: got ret=%h required %h", retired, m_ret);
        end
    endtask

    initial begin
        test_reset();
        test_fwd_write_read();
        test_carry();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Register-file and writeback stage for the 16-bit CPU.
- Upstream role: decodes rm/rn from the current instruction and drives inreg1, inreg2 and carryin into the ALU.
- Downstream role: captures aluout, carryout, carryen and wenout into a one-entry writeback register, then commits them to the 4x16 register file and the carry flag.
- Includes a forwarding path from the writeback register and a retired-instruction counter.

Parameters:
- DW, 16, datapath width.
- NREG, 4, number of architectural registers; address width is 2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  16  instruction presented to the ALU this cycle. Fields: rd=[7:6], rm=[5:4], rn=[3:2].
- valid  input  1  instr is a real instruction this cycle; 0 means bubble.
- aluout  input  16  ALU result for instr.
- carryout  input  1  ALU carry for instr.
- carryen  input  1  instr updates the carry flag.
- wenout  input  1  instr writes rd.
- inreg1  output  16  operand A, value of register rm (forwarded).
- inreg2  output  16  operand B, value of register rn (forwarded).
- carryin  output  1  current architectural carry flag (forwarded).
- retired  output  16  count of committed valid instructions.

Behaviour:
- State:
  - rf[0..3] (16b each), cflag.
  - Writeback register: wbvalid, wbrd, wbdata, wbcarry, wbwen, wbcen.
  - retired counter.
- Reset (rst=1 at an edge):
  - rf, cflag and retired clear to 0; all wb* clear to 0.
  - A pending writeback is discarded and never commits.
  - The same edge performs no capture.
- Outputs after reset: inreg1=inreg2=0, carryin=0, retired=0.
- Capture edge, every non-reset edge:
  - wbvalid<=valid, wbrd<=rd, wbdata<=aluout, wbcarry<=carryout.
  - wbwen<=valid&wenout, wbcen<=valid&carryen.
- Commit, same edge, using the old wb* values:
  - wbwen: rf[wbrd]<=wbdata.
  - wbcen: cflag<=wbcarry.
  - wbvalid: retired<=retired+1, wrapping 0xFFFF->0x0000.
- Latency: result visible architecturally 2 edges after presentation, and to dependent instructions 1 cycle after via forwarding.
- Forwarding (combinational):
  - inreg1 = (wbwen && wbrd==rm) ? wbdata : rf[rm]; same rule for inreg2 with rn.
  - carryin = wbcen ? wbcarry : cflag.
- Boundary conditions:
  - rm==rn: both ports forward identically.
  - rd==rm for the current instr: reads the old value; no combinational loop through aluout.
  - Back-to-back writes to the same rd: the later write wins.
  - Bubble (valid=0): no rf, flag or counter change at its commit.
  - wenout=1 with carryen=0: flag is untouched, and vice versa.
- No stall input. The pipeline advances every cycle; bubbles are inserted via valid.

Optional Feature:
- Macro REGFILE_DBG_EN.
- Defined:
  - Adds input dbgsel[1:0] and output dbgdata[15:0].
  - dbgdata = rf[dbgsel], the architectural value without forwarding, registered (1-cycle latency, reset 0).
  - Adds output dbgcflag = cflag.
- Undefined: these ports and their logic do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - DW and NREG.
  - Field positions RD_HI/LO, RM_HI/LO, RN_HI/LO, CEN_BIT, CUSE_BIT.
  - Opcode constants OP_ADD=8'hF8, OP_SUB=8'hF9, OP_INC=8'hFA, OP_DEC=8'hFB.
- Sub-module regfile4: storage array with 2 combinational read ports, 1 synchronous write port and reset clear.
- Forwarding, writeback register and counter stay in regfile_wb.

Test Plan:
1. Reset then idle: rst 1 for 2 cycles, valid=0 for 3 -> inreg1=inreg2=0, carryin=0, retired=0 throughout.
2. Write then dependent read: cycle0 rd=1, aluout=0x1234, wenout=1. Cycle1 rm=1 -> inreg1=0x1234 via forward. Cycle2 rm=1 -> 0x1234 from rf. retired=1 after cycle1 edge.
3. Carry path: cycle0 carryen=1, carryout=1, wenout=0. Cycle1 -> carryin=1, rf unchanged. Then carryen=0 instr -> carryin stays 1.
4. Back-to-back same rd: rd=2 writes 0x0001, then 0x0002. Following rm=rn=2 -> both ports 0x0002. rf[2]=0x0002 after 2 more edges.
5. Reset mid-flight: valid write rd=3, 0xBEEF, with rst asserted on the next edge -> rf[3]=0, retired=0, no later commit of 0xBEEF.
6. Counter wrap: preload via 65535 valid instrs, then one more -> retired goes 0xFFFF to 0x0000. Bubbles interleaved do not count.
